sysarray_ctrl: RTL and testbench

Sequencer for the N×N output-stationary systolic array (sysArray datapath). It captures an A/B operand pair on a start handshake and clears the PE accumulators. It then streams skewed row/column wavefronts into the array edges, waits a fixed drain interval, and latches the array result. The result is presented on a valid/ready output handshake. It sits between the operand source (DMA/testbench) and the array.

---
 rtl/sysarray_ctrl_if.sv | 32 +++
 rtl/sysarray_ctrl.sv | 120 ++++++++++++
 tb/tb_sysarray_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysarray_ctrl_if.sv
// Handshake and data bundle between the operand source, the sequencer and the array.
interface sysarray_ctrl_if #(
  parameter int n           = 8,
  parameter int matrix_size = 4
);
  logic start;
  logic ready_in;
  logic abort;
  logic [matrix_size-1:0][matrix_size-1:0][n-1:0]   a_in;
  logic [matrix_size-1:0][matrix_size-1:0][n-1:0]   b_in;
  logic [matrix_size-1:0][n-1:0]                    a_feed;
  logic [matrix_size-1:0][n-1:0]                    b_feed;
  logic pe_clear;
  logic pe_en;
  logic [matrix_size-1:0][matrix_size-1:0][2*n-1:0] c_in;
  logic [matrix_size-1:0][matrix_size-1:0][2*n-1:0] c_out;
  logic out_valid;
  logic out_ready;
  logic busy;

  // Source / array side.
  modport master (
    output start, abort, a_in, b_in, c_in, out_ready,
    input  ready_in, a_feed, b_feed, pe_clear, pe_en, c_out, out_valid, busy
  );

  // Sequencer side.
  modport slave (
    input  start, abort, a_in, b_in, c_in, out_ready,
    output ready_in, a_feed, b_feed, pe_clear, pe_en, c_out, out_valid, busy
  );
endinterface

// File: rtl/sysarray_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: captures A/B, clears
// the PEs, streams skewed wavefronts, drains, then holds C on valid/ready.
// All array-facing outputs are registered from the current state, so they
// trail the FSM by one cycle.
module sysarray_ctrl #(
  parameter int n           = 8,
  parameter int matrix_size = 4,
  parameter int DRAIN_CYC   = 2
) (
  input  logic           clk,
  input  logic           rst,
  sysarray_ctrl_if.slave bus
);
  localparam int N    = matrix_size;
  localparam int CMAX = (3*N > DRAIN_CYC) ? 3*N : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(3*N - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nx;
  logic accept;
  logic [N-1:0][N-1:0][n-1:0] a_q, b_q;
  logic [N-1:0][n-1:0] a_nx, b_nx;

  assign bus.ready_in = (state == IDLE);
  assign bus.busy     = (state != IDLE);

  // State and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nx;
    end
  end

  // Next state; abort overrides everything and drops a same-cycle start.
  always_comb begin
    nxt    = state;
    cnt_nx = cnt;
    accept = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin nxt = CLEAR; accept = 1'b1; end
      CLEAR: begin nxt = FEED; cnt_nx = '0; end
      FEED:  if (cnt == FEED_LAST) begin nxt = DRAIN; cnt_nx = '0; end
             else cnt_nx = cnt + 1'b1;
      DRAIN: if (cnt == DRAIN_LAST) begin nxt = HOLD; cnt_nx = '0; end
             else cnt_nx = cnt + 1'b1;
      HOLD:  if (bus.out_valid && bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort) begin
      nxt    = IDLE;
      cnt_nx = '0;
      accept = 1'b0;
    end
  end

  // Operand capture on the start-accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= bus.a_in;
      b_q <= bus.b_in;
    end
  end

  // Wavefront skew: row i / column j carries element k when cnt == lane + k.
  always_comb begin
    a_nx = '0;
    b_nx = '0;
    if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cnt == CW'(i + k)) begin
            a_nx[i] = a_q[i][k];
            b_nx[i] = b_q[k][i];
          end
        end
      end
    end
  end

  // Registered array controls, feeds and result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pe_clear  <= 1'b0;
      bus.pe_en     <= 1'b0;
      bus.a_feed    <= '0;
      bus.b_feed    <= '0;
      bus.out_valid <= 1'b0;
      bus.c_out     <= '0;
    end else if (bus.abort) begin
      bus.pe_clear  <= 1'b0;
      bus.pe_en     <= 1'b0;
      bus.a_feed    <= '0;
      bus.b_feed    <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.pe_clear <= (state == CLEAR);
      bus.pe_en    <= (state == FEED) || (state == DRAIN);
      bus.a_feed   <= a_nx;
      bus.b_feed   <= b_nx;
      // First HOLD edge is the last edge the array is advanced: sample C once.
      if (state == HOLD && !bus.out_valid) begin
        bus.out_valid <= 1'b1;
        bus.c_out     <= bus.c_in;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sysarray_ctrl.sv
// Scoreboard bench for sysarray_ctrl with a behavioural systolic array attached.
module tb_sysarray_ctrl;
  localparam int n         = 8;
  localparam int N         = 4;
  localparam int DRAIN_CYC = 2;
  localparam int LAT       = 3*N + DRAIN_CYC;

  typedef logic [N-1:0][N-1:0][n-1:0]   mat_t;
  typedef logic [N-1:0][N-1:0][2*n-1:0] cmat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sysarray_ctrl_if #(.n(n), .matrix_size(N)) bus();

  sysarray_ctrl #(.n(n), .matrix_size(N), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int    chk_cnt = 0;
  int    pass_cnt = 0;
  cmat_t exp_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int sx(input logic [n-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference: plain signed matrix product, wrapped to the result width.
  function automatic cmat_t matmul(input mat_t a, input mat_t b);
    cmat_t c;
    int s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += sx(a[i][k]) * sx(b[k][j]);
        c[i][j] = s[2*n-1:0];
      end
    return c;
  endfunction

  function automatic mat_t rmat();
    mat_t m;
    logic [31:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = $urandom;
        m[i][j] = r[n-1:0];
      end
    return m;
  endfunction

  // Behavioural output-stationary array: A flows right, B flows down.
  int         acc [N][N];
  logic [n-1:0] a_r [N][N];
  logic [n-1:0] b_r [N][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.pe_clear) begin
      acc <= '{default: 0};
      a_r <= '{default: '0};
      b_r <= '{default: '0};
    end else if (bus.pe_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j]
            + sx(j == 0 ? bus.a_feed[i] : a_r[i][(j == 0) ? 0 : j-1])
            * sx(i == 0 ? bus.b_feed[j] : b_r[(i == 0) ? 0 : i-1][j]);
          a_r[i][j] <= (j == 0) ? bus.a_feed[i] : a_r[i][(j == 0) ? 0 : j-1];
          b_r[i][j] <= (i == 0) ? bus.b_feed[j] : b_r[(i == 0) ? 0 : i-1][j];
        end
    end
  end

  always_comb begin
    bus.c_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.c_in[i][j] = 16'(acc[i][j]);
  end

  // Monitor: on each negedge, rel = edges since the accept edge + 1.
  int    cyc = 0;
  int    run_start = 0;
  int    rel = 0;
  int    t = 0;
  bit    active = 0;
  mat_t  capA, capB;
  cmat_t held;
  logic [N-1:0][n-1:0] ea, eb;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) active = 0;
      else begin
        if (active) begin
          rel = cyc - run_start;
          t   = rel - 3;
          ea  = '0;
          eb  = '0;
          for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
              ea[i] = capA[i][t-i];
              eb[i] = capB[t-i][i];
            end
          end
          chk("pe_clear", bus.pe_clear, rel == 2);
          chk("pe_en", bus.pe_en, (rel >= 3) && (rel <= LAT));
          chk("a_feed", bus.a_feed, ea);
          chk("b_feed", bus.b_feed, eb);
          if (rel >= 1) chk("busy_ready", {bus.busy, bus.ready_in}, 2'b10);
          if (rel <= LAT) chk("out_valid_early", bus.out_valid, 0);
          else if (rel == LAT + 1) begin
            chk("latency", bus.out_valid, 1);
            chk("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("c_out", bus.c_out, exp_q.pop_front());
            held = bus.c_out;
          end else begin
            chk("c_out_hold", bus.c_out, held);
            chk("out_valid_hold", bus.out_valid, 1);
          end
          if (rel > LAT && bus.out_valid && bus.out_ready) active = 0;
          if (bus.abort) active = 0;
        end else begin
          chk("idle_ctrl", {bus.pe_clear, bus.pe_en, bus.out_valid, bus.busy, bus.ready_in}, 5'b00001);
        end
        if (!active && bus.ready_in && bus.start && !bus.abort) begin
          active    = 1;
          run_start = cyc;
          capA      = bus.a_in;
          capB      = bus.b_in;
        end
      end
    end
  end

  task automatic start_run(input mat_t a, input mat_t b, input bit push);
    int k = 0;
    while (!bus.ready_in && k < 60) begin @(posedge clk); #1; k++; end
    chk("ready_wait", bus.ready_in, 1);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1;
    if (push) exp_q.push_back(matmul(a, b));
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 60) begin @(posedge clk); #1; k++; end
    chk("valid_wait", bus.out_valid, 1);
  endtask

  task automatic wait_drop();
    int k = 0;
    while (bus.out_valid && k < 60) begin @(posedge clk); #1; k++; end
    chk("drop_wait", bus.out_valid, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

  int av [4][4] = '{'{-1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, -11, 12}, '{13, 14, 15, 15}};
  int bv [4][4] = '{'{1, 1, 1, 1}, '{2, 2, -2, 2}, '{3, 3, 3, 3}, '{4, 4, 4, 4}};

  initial begin : driver
    mat_t ad, bd, id, rb;
    int   tmp;
    int   bp;
    bus.start = 0; bus.abort = 0; bus.out_ready = 1;
    bus.a_in = '0; bus.b_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tmp = av[i][j]; ad[i][j] = tmp[n-1:0];
        tmp = bv[i][j]; bd[i][j] = tmp[n-1:0];
        id[i][j] = (i == j) ? 8'd1 : 8'd0;
      end

    // Reset held for two cycles, sampled mid-clock.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ready_busy", {bus.ready_in, bus.busy}, 2'b10);
    chk("rst_ctrl", {bus.pe_clear, bus.pe_en, bus.out_valid}, 3'b000);
    chk("rst_feeds", {bus.a_feed, bus.b_feed}, '0);
    chk("rst_c_out", bus.c_out, '0);
    rst = 0;
    @(posedge clk); #1;

    // Directed skew / end-to-end matrices.
    start_run(ad, bd, 1);
    wait_valid();
    chk("C00", bus.c_out[0][0], 16'd28);
    chk("C02", bus.c_out[0][2], 16'd20);
    chk("C20", bus.c_out[2][0], 16'd44);
    wait_drop();
    chk("ready_after_hs", bus.ready_in, 1);

    // Backpressure with ignored start pulses.
    bus.out_ready = 0;
    start_run(rmat(), rmat(), 1);
    wait_valid();
    repeat (5) begin
      @(posedge clk); #1;
      bus.start = 1'($urandom_range(0, 1));
      bus.a_in  = rmat();
    end
    bus.start = 0;
    bus.out_ready = 1;
    wait_drop();

    // Abort during FEED t=4, then identity times B.
    start_run(rmat(), rmat(), 0);
    repeat (6) @(posedge clk);
    #1 bus.abort = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    chk("abort_idle", {bus.ready_in, bus.pe_en, bus.out_valid}, 3'b100);
    rb = rmat();
    start_run(id, rb, 1);
    wait_valid();
    wait_drop();

    // Abort and start together in IDLE: start dropped.
    bus.a_in = rmat(); bus.start = 1; bus.abort = 1;
    @(posedge clk); #1;
    bus.start = 0; bus.abort = 0;
    chk("abort_beats_start", {bus.ready_in, bus.busy}, 2'b10);

    // Back-to-back runs plus random backpressure.
    for (int r = 0; r < 20; r++) begin
      bp = $urandom_range(0, 3);
      bus.out_ready = (bp == 0);
      start_run(rmat(), rmat(), 1);
      wait_valid();
      repeat (bp) begin @(posedge clk); #1; end
      bus.out_ready = 1;
      wait_drop();
    end

    // Asynchronous reset mid-run.
    start_run(rmat(), rmat(), 0);
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst", {bus.ready_in, bus.busy, bus.pe_en, bus.out_valid, bus.pe_clear}, 5'b10000);
    chk("async_rst_feeds", {bus.a_feed, bus.b_feed}, '0);
    chk("async_rst_c_out", bus.c_out, '0);
    @(posedge clk); #3 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
